// File: rtl/memory_controller_pkg.sv
// memory_controller_pkg
//   Shared constants for the stream buffer: default data/address widths and
//   the width of one stored word {tlast, tstrb, tdata}.
package memory_controller_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  // One stored word: data, one strobe bit per byte, and tlast.
  function automatic int word_width(input int dw);
    return dw + dw / 8 + 1;
  endfunction
endpackage

// File: rtl/memory_controller_ram.sv
// memory_controller_ram
//   Simple dual-port storage array: synchronous write, asynchronous read.
//   Contents are not reset.
//   Ports:
//     i_clk    clock
//     i_we     write enable
//     i_waddr  write address
//     i_wdata  write word
//     i_raddr  read address
//     o_rdata  read word (combinational)
module memory_controller_ram #(
  parameter int WIDTH      = 37,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/memory_controller.sv
// memory_controller
//   DEPTH-word in-order AXI-Stream buffer with first-word-fall-through output.
//   Each word is stored as {tlast, tstrb, tdata}.
//   Optional build macro MEMORY_CONTROLLER_STORE_FWD_EN: output valid is held
//   back until a complete packet (a stored tlast) is present or the buffer is
//   full (the full case avoids deadlock on packets longer than the buffer).
//   Ports:
//     s01_axis_aclk / s01_axis_aresetn  clock, async active-low reset
//     s01_axis_t*                       write-side stream (slave)
//     m01_axis_t*                       read-side stream (master)
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    s01_axis_aclk,
  input  logic                    s01_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int WW = word_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = CNT_ONE << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;

  logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic                  r_s_tready, r_m_tvalid;
  logic                  w_wr, w_rd, w_vld_nxt;
  logic [WW-1:0]         w_wr_word, w_rd_word;

  assign w_wr      = s01_axis_tvalid & r_s_tready;
  assign w_rd      = r_m_tvalid & m01_axis_tready;
  assign w_wr_word = {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

`ifdef MEMORY_CONTROLLER_STORE_FWD_EN
  // Number of stored words carrying tlast; nonzero means a whole packet is in.
  logic [ADDR_WIDTH:0] r_last_cnt, w_last_nxt;
  logic                w_wr_last, w_rd_last;

  assign w_wr_last = w_wr & s01_axis_tlast;
  assign w_rd_last = w_rd & w_rd_word[WW-1];

  always_comb begin
    w_last_nxt = r_last_cnt;
    case ({w_wr_last, w_rd_last})
      2'b10:   w_last_nxt = r_last_cnt + CNT_ONE;
      2'b01:   w_last_nxt = r_last_cnt - CNT_ONE;
      default: w_last_nxt = r_last_cnt;
    endcase
  end

  always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
    if (!s01_axis_aresetn) r_last_cnt <= '0;
    else                   r_last_cnt <= w_last_nxt;
  end

  assign w_vld_nxt = (w_count_nxt != '0) &&
                     ((w_last_nxt != '0) || (w_count_nxt == CNT_DEPTH));
`else
  assign w_vld_nxt = (w_count_nxt != '0);
`endif

  // Flags are registered from the next-state count so they line up with
  // the pointers/count after each edge (1-cycle write-to-output latency).
  always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
    if (!s01_axis_aresetn) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_s_tready <= (w_count_nxt != CNT_DEPTH);
      r_m_tvalid <= w_vld_nxt;
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  memory_controller_ram #(
    .WIDTH      (WW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (s01_axis_aclk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_word),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_word)
  );

  assign s01_axis_tready = r_s_tready;
  assign m01_axis_tvalid = r_m_tvalid;
  // Output fields are zeroed whenever nothing valid is presented.
  assign m01_axis_tdata  = r_m_tvalid ? w_rd_word[DATA_WIDTH-1:0]           : '0;
  assign m01_axis_tstrb  = r_m_tvalid ? w_rd_word[DATA_WIDTH +: SW]         : '0;
  assign m01_axis_tlast  = r_m_tvalid ? w_rd_word[WW-1]                     : 1'b0;
endmodule

// File: tb/tb_memory_controller.sv
module tb_memory_controller;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic          m_tvalid, m_tlast, m_tready;

  always #5 clk = ~clk;

  memory_controller dut (
    .s01_axis_aclk    (clk),
    .s01_axis_aresetn (rst_n),
    .s01_axis_tdata   (s_tdata),
    .s01_axis_tstrb   (s_tstrb),
    .s01_axis_tvalid  (s_tvalid),
    .s01_axis_tlast   (s_tlast),
    .s01_axis_tready  (s_tready),
    .m01_axis_tdata   (m_tdata),
    .m01_axis_tstrb   (m_tstrb),
    .m01_axis_tvalid  (m_tvalid),
    .m01_axis_tlast   (m_tlast),
    .m01_axis_tready  (m_tready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of {tlast, tstrb, tdata} words.
  logic [DW+SW:0] q[$];
  bit             m_block;      // in reset / before first edge after release
  bit             last_wr, last_rd;
  logic [DW-1:0]  last_rd_data;

  function automatic bit model_vld();
    bit any_last = 0;
    if (m_block || q.size() == 0) return 0;
`ifdef MEMORY_CONTROLLER_STORE_FWD_EN
    foreach (q[i]) if (q[i][DW+SW]) any_last = 1;
    return any_last || (q.size() == DEPTH);
`else
    return 1;
`endif
  endfunction

  // One clock: check outputs at the negedge, then apply handshakes at posedge.
  task automatic step();
    bit             exp_rdy, exp_vld;
    logic [DW+SW:0] head;
    @(negedge clk);
    exp_rdy = !m_block && (q.size() != DEPTH);
    exp_vld = model_vld();
    head    = exp_vld ? q[0] : '0;
    check("tready", s_tready, exp_rdy);
    check("tvalid", m_tvalid, exp_vld);
    check("tdata",  m_tdata,  head[DW-1:0]);
    check("tstrb",  m_tstrb,  head[DW +: SW]);
    check("tlast",  m_tlast,  head[DW+SW]);
    last_wr      = s_tvalid && exp_rdy;
    last_rd      = exp_vld && m_tready;
    last_rd_data = m_tdata;
    @(posedge clk);
    if (last_rd) void'(q.pop_front());
    if (last_wr) q.push_back({s_tlast, s_tstrb, s_tdata});
    if (rst_n) m_block = 0;
    #1;
  endtask

  initial begin
    int n_acc, next_wr, next_rd, guard;
    rst_n = 0; s_tdata = '0; s_tstrb = '0; s_tvalid = 0; s_tlast = 0; m_tready = 0;
    m_block = 1;

    // Reset held 5 cycles, then release; tready rises after the first edge.
    repeat (5) step();
    rst_n = 1;
    step();
    step();

    // Fill: constant word, no reader.
    s_tdata = 32'h68; s_tstrb = 4'h1; s_tlast = 1; s_tvalid = 1; m_tready = 0;
    n_acc = 0;
    repeat (20) begin
      step();
      if (last_wr) n_acc++;
    end
    check("fill_count", n_acc, 16);
    step();

    // Drain from full while still writing: one beat per cycle.
    m_tready = 1;
    repeat (20) begin
      step();
      check("drain_beat", last_rd, 1);
      check("drain_data", last_rd_data, 32'h68);
    end

    // Empty the buffer.
    s_tvalid = 0;
    guard = 0;
    while (q.size() != 0 && guard < 40) begin step(); guard++; end
    step();

    // Ordering and wrap: 0..39 with random backpressure.
    next_wr = 0; next_rd = 0; guard = 0;
    while (next_rd < 40 && guard < 600) begin
      s_tvalid = (next_wr < 40) && ($urandom_range(3) != 0);
      s_tdata  = next_wr;
      s_tstrb  = 4'($urandom);
      s_tlast  = (next_wr == 39) || ($urandom_range(1) == 1);
      m_tready = ($urandom_range(2) != 0);
      step();
      if (last_wr) next_wr++;
      if (last_rd) begin
        check("order", last_rd_data, next_rd);
        next_rd++;
      end
      guard++;
    end
    check("order_done", next_rd, 40);
    s_tvalid = 0; m_tready = 0;
    step();

    // Empty: single word, then read it out.
    s_tdata = 32'hA5; s_tstrb = 4'hF; s_tlast = 1; s_tvalid = 1;
    step();
    s_tvalid = 0; m_tready = 1;
    step();
    check("empty_rd", last_rd_data, 32'hA5);
    step();
    check("empty_vld", m_tvalid, 0);
    check("empty_dat", m_tdata, 0);

`ifdef MEMORY_CONTROLLER_STORE_FWD_EN
    // Store-and-forward: valid held until a tlast word is stored.
    m_tready = 0; s_tvalid = 1; s_tlast = 0;
    for (int i = 0; i < 3; i++) begin s_tdata = 32'h100 + i; step(); end
    step();
    check("sf_hold", m_tvalid, 0);
    s_tdata = 32'h103; s_tlast = 1;
    step();
    s_tvalid = 0;
    step();
    check("sf_release", m_tvalid, 1);
`endif

    // Mid-operation reset discards stored words.
    s_tvalid = 1; s_tlast = 1; m_tready = 0;
    repeat (4) step();
    s_tvalid = 0;
    rst_n = 0;
    #2;
    check("rst_tready", s_tready, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata",  m_tdata,  0);
    q.delete();
    m_block = 1;
    step();
    rst_n = 1;
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
